// File: rtl/memory_master_pkg.sv
// Shared encodings for the main-memory initiator: FSM states, operation type,
// and the default bus width.
package memory_master_pkg;

  localparam int DATAWIDTH_BUS_DEFAULT = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Width of a counter that must represent values 0..max_count.
  function automatic int counter_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/memory_master_timer.sv
// Request timeout counter: cleared when a request is accepted, counts REQ cycles
// without ACK, and flags the last allowed cycle. Saturates rather than wrapping.
module memory_master_timer
  import memory_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = counter_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/memory_master.sv
// Single-request initiator for the RD/WR/ACK main-memory bus, with a bounded
// wait for ACK that completes the request with an error flag on expiry.
module memory_master
  import memory_master_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_BUS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                     MEMORY_MASTER_CLOCK_50,
  input  logic                     MEMORY_MASTER_RESET_InHigh,
  input  logic                     MEMORY_MASTER_RD_Start_In,
  input  logic                     MEMORY_MASTER_WR_Start_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_WRDATA_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_RDDATA_OutBUS,
  output logic                     MEMORY_MASTER_BUSY_Out,
  output logic                     MEMORY_MASTER_DONE_Out,
  output logic                     MEMORY_MASTER_ERROR_Out,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_MEM_data_OutBUS,
  output logic                     MEMORY_MASTER_MEM_RD_Out,
  output logic                     MEMORY_MASTER_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_MASTER_MEM_data_InBUS,
  input  logic                     MEMORY_MASTER_MEM_ACK_In
);

  // Handshake: a start is accepted only in IDLE (RD wins over WR); the strobe
  // then stays high until ACK or timeout, and DONE pulses once afterwards.
  state_t state;
  op_t    op;
  logic   accept;
  logic   timer_expire;

  assign accept = (state == IDLE) &&
                  (MEMORY_MASTER_RD_Start_In || MEMORY_MASTER_WR_Start_In);

  memory_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (MEMORY_MASTER_CLOCK_50),
    .reset  (MEMORY_MASTER_RESET_InHigh),
    .clear  (accept),
    .enable (state == REQ),
    .expire (timer_expire)
  );

  always_ff @(posedge MEMORY_MASTER_CLOCK_50) begin
    if (MEMORY_MASTER_RESET_InHigh) begin
      state                            <= IDLE;
      op                               <= OP_READ;
      MEMORY_MASTER_RDDATA_OutBUS      <= '0;
      MEMORY_MASTER_MEM_ADDRESS_OutBUS <= '0;
      MEMORY_MASTER_MEM_data_OutBUS    <= '0;
      MEMORY_MASTER_BUSY_Out           <= 1'b0;
      MEMORY_MASTER_DONE_Out           <= 1'b0;
      MEMORY_MASTER_ERROR_Out          <= 1'b0;
      MEMORY_MASTER_MEM_RD_Out         <= 1'b0;
      MEMORY_MASTER_MEM_WR_Out         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MEMORY_MASTER_DONE_Out <= 1'b0;
          if (MEMORY_MASTER_RD_Start_In) begin
            state                            <= REQ;
            op                               <= OP_READ;
            MEMORY_MASTER_MEM_ADDRESS_OutBUS <= MEMORY_MASTER_ADDRESS_InBUS;
            MEMORY_MASTER_MEM_RD_Out         <= 1'b1;
            MEMORY_MASTER_BUSY_Out           <= 1'b1;
            MEMORY_MASTER_ERROR_Out          <= 1'b0;
          end else if (MEMORY_MASTER_WR_Start_In) begin
            state                            <= REQ;
            op                               <= OP_WRITE;
            MEMORY_MASTER_MEM_ADDRESS_OutBUS <= MEMORY_MASTER_ADDRESS_InBUS;
            MEMORY_MASTER_MEM_data_OutBUS    <= MEMORY_MASTER_WRDATA_InBUS;
            MEMORY_MASTER_MEM_WR_Out         <= 1'b1;
            MEMORY_MASTER_BUSY_Out           <= 1'b1;
            MEMORY_MASTER_ERROR_Out          <= 1'b0;
          end
        end

        REQ: begin
          // ACK on the last allowed cycle still counts as a clean completion.
          if (MEMORY_MASTER_MEM_ACK_In || timer_expire) begin
            state                    <= DONE;
            MEMORY_MASTER_MEM_RD_Out <= 1'b0;
            MEMORY_MASTER_MEM_WR_Out <= 1'b0;
            MEMORY_MASTER_DONE_Out   <= 1'b1;
            MEMORY_MASTER_ERROR_Out  <= !MEMORY_MASTER_MEM_ACK_In;
            if (op == OP_READ) begin
              MEMORY_MASTER_RDDATA_OutBUS <= MEMORY_MASTER_MEM_data_InBUS;
            end
          end
        end

        DONE: begin
          state                  <= IDLE;
          MEMORY_MASTER_DONE_Out <= 1'b0;
          MEMORY_MASTER_BUSY_Out <= 1'b0;
        end

        default: begin
          state                    <= IDLE;
          MEMORY_MASTER_DONE_Out   <= 1'b0;
          MEMORY_MASTER_BUSY_Out   <= 1'b0;
          MEMORY_MASTER_MEM_RD_Out <= 1'b0;
          MEMORY_MASTER_MEM_WR_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_master.md
# memory_master

Initiator for the main-memory RD/WR/ACK bus. It accepts single read or write requests from the CPU datapath, drives address, write data and RD/WR strobes to main memory, waits for ACK, and returns read data with a completion pulse. A bounded timeout covers a memory that never drives ACK: on expiry the data bus is sampled anyway and an error is flagged. It sits between the datapath/control unit and MAIN_MEMORY.

## Interface
- DATAWIDTH_BUS, 32, width of the address and data buses
- TIMEOUT_CYCLES, 15, number of REQ cycles without ACK before the request is forced complete (legal range ≥1)
- MEMORY_MASTER_CLOCK_50  input  1  the only clock; all state changes on its rising edge
- MEMORY_MASTER_RESET_InHigh  input  1  synchronous, active-high reset
- MEMORY_MASTER_RD_Start_In  input  1  CPU read request, sampled only in IDLE
- MEMORY_MASTER_WR_Start_In  input  1  CPU write request, sampled only in IDLE
- MEMORY_MASTER_ADDRESS_InBUS  input  DATAWIDTH_BUS  CPU request address
- MEMORY_MASTER_WRDATA_InBUS  input  DATAWIDTH_BUS  CPU write data
- MEMORY_MASTER_RDDATA_OutBUS  output  DATAWIDTH_BUS  last completed read data (registered)
- MEMORY_MASTER_BUSY_Out  output  1  high in REQ and DONE
- MEMORY_MASTER_DONE_Out  output  1  one-cycle completion pulse
- MEMORY_MASTER_ERROR_Out  output  1  last request ended by timeout
- MEMORY_MASTER_MEM_ADDRESS_OutBUS  output  DATAWIDTH_BUS  address to memory
- MEMORY_MASTER_MEM_data_OutBUS  output  DATAWIDTH_BUS  write data to memory
- MEMORY_MASTER_MEM_RD_Out  output  1  read strobe to memory
- MEMORY_MASTER_MEM_WR_Out  output  1  write strobe to memory
- MEMORY_MASTER_MEM_data_InBUS  input  DATAWIDTH_BUS  read data from memory
- MEMORY_MASTER_MEM_ACK_In  input  1  memory acknowledge

## Operation
- States: IDLE, REQ, DONE. Reset leads to IDLE.
- IDLE: if RD_Start=1, latch the address, set op=read, and go to REQ. Else if WR_Start=1, latch the address and write data, set op=write, and go to REQ. If both are high, the request is a read and WR is ignored. On acceptance, clear ERROR and the timeout counter.
- REQ: MEM_RD or MEM_WR (per op) is high; MEM_ADDRESS and MEM_data_Out hold the latched values. Each cycle:
  - ACK=1: go to DONE, ERROR=0. For a read, capture MEM_data_In into RDDATA.
  - ACK=0 with counter = TIMEOUT_CYCLES-1: go to DONE, ERROR=1. For a read, capture MEM_data_In anyway.
  - Otherwise: counter+1 and stay in REQ.
- DONE: strobes low, DONE_Out=1 for exactly one cycle, then go to IDLE.
- Starts arriving in REQ or DONE are ignored; they are not queued.
- Writes never change RDDATA. RDDATA holds its value until the next read completes.
- Outputs are registered (Moore).
- MEM_ADDRESS and MEM_data_Out hold their last latched values in IDLE and DONE.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter never wraps.
- Reset values:
  - RDDATA=0, MEM_ADDRESS=0, MEM_data_Out=0
  - BUSY=0, DONE=0, ERROR=0, MEM_RD=0, MEM_WR=0
  - counter=0, op=read
- Reset mid-request: strobes drop at that edge, no DONE pulse, RDDATA is cleared.

## Timing
- Cycle 0: Start high in IDLE.
- Cycle 1: REQ, strobe high, BUSY=1. ACK is sampled from this cycle onward.
- ACK seen in cycle k (k≥1): cycle k+1 is DONE, with DONE=1, RDDATA valid and strobe low.
- Cycle k+2: IDLE, BUSY=0, new start accepted.
- Minimum turnaround is 3 cycles per request.
- Timeout with no ACK: REQ occupies cycles 1..TIMEOUT_CYCLES. DONE with ERROR=1 follows in cycle TIMEOUT_CYCLES+1.
- ACK is ignored outside REQ.
- ACK on the final timeout cycle counts as ACK (ERROR=0).

## Structure
- Shared include/package contents:
  - state encoding localparams (IDLE=2'b00, REQ=2'b01, DONE=2'b10)
  - op encoding
  - DATAWIDTH_BUS default
- One sub-module, memory_master_timer:
  - load-clear on accept, increment enable in REQ
  - expire output at TIMEOUT_CYCLES-1, sync active-high reset
- FSM, request latches and the RDDATA register stay in the top module.

## Test plan
- Read, ACK in first REQ cycle: RD_Start, addr 0x800, MEM_data_In=0xC6002001 → MEM_RD high 1 cycle, DONE in cycle 2, RDDATA=0xC6002001, ERROR=0.
- Write, ACK after 3 cycles: WR_Start, addr 0x804, data 0xDEADBEEF → MEM_WR high cycles 1–4, MEM_data_Out=0xDEADBEEF, DONE in cycle 5, RDDATA unchanged.
- No ACK, TIMEOUT_CYCLES=15, MEM_data_In=0x00000804:
  - MEM_RD high cycles 1–15, DONE with ERROR=1 in cycle 16, RDDATA=0x00000804.
  - ERROR clears on the next accepted start.
- RD and WR start together, then a start while BUSY: the transaction is a read, MEM_WR never asserts, the second start is ignored, and exactly one DONE pulse occurs.
- Reset asserted in REQ cycle 2: MEM_RD=0, BUSY=0 and RDDATA=0 after that edge, no DONE pulse, next start is accepted normally.
